// File: rtl/set_cache_replacement_sequencer.sv
// Sequencer between a cache controller and a shared PLRU/SRRIP policy controller: buffers hit
// updates, serialises victim requests. Optional WAIT timeout enabled by defining SEQ_TIMEOUT_EN.
module set_cache_replacement_sequencer #(
  parameter int unsigned CACHE_BLOCK_CAPACITY = 128,
  parameter int unsigned CACHE_SET_SIZE       = 4,
  parameter int unsigned HIT_FIFO_DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES       = 16,
  localparam int unsigned BW_CAP = $clog2(CACHE_BLOCK_CAPACITY),
  localparam int unsigned BW_SET = $clog2(CACHE_SET_SIZE),
  localparam int unsigned BW_GRP = BW_CAP - BW_SET
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              hit_valid_i,
  input  logic [BW_CAP-1:0] hit_addr_i,
  output logic              hit_ready_o,
  input  logic              req_valid_i,
  input  logic [BW_GRP-1:0] req_group_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [BW_CAP-1:0] rsp_addr_o,
  output logic              rsp_err_o,
  input  logic              rsp_ready_i,
  output logic              pol_hit_o,
  output logic              pol_miss_o,
  output logic [BW_CAP-1:0] pol_addr_o,
  input  logic              pol_done_i,
  input  logic [BW_CAP-1:0] pol_addr_i,
  output logic              busy_o
);

  localparam int unsigned BW_FIFO = $clog2(HIT_FIFO_DEPTH);
  localparam int unsigned PTR_W   = BW_FIFO + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [BW_GRP-1:0] grp_q, grp_d;
  logic [BW_CAP-1:0] rsp_addr_q, rsp_addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW_CAP-1:0] fifo_mem [HIT_FIFO_DEPTH];
  logic              fifo_empty, fifo_full, push;
  logic [BW_CAP-1:0] miss_addr;
  logic [BW_GRP-1:0] unused_pol_addr_lo;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
  assign rsp_err_o = rsp_err_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign rsp_err_o = 1'b0;
`endif

  // Full when the pointers differ only in the wrap bit.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[BW_FIFO] != rd_ptr_q[BW_FIFO]) &&
                      (wr_ptr_q[BW_FIFO-1:0] == rd_ptr_q[BW_FIFO-1:0]);
  assign push       = hit_valid_i & ~fifo_full;
  assign miss_addr  = {{BW_SET{1'b0}}, grp_q};

  assign hit_ready_o        = ~fifo_full;
  assign rsp_valid_o        = (state_q == ST_RESP);
  assign rsp_addr_o         = rsp_addr_q;
  assign busy_o             = (state_q != ST_IDLE) | ~fifo_empty;
  assign unused_pol_addr_lo = pol_addr_i[BW_GRP-1:0];

  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    rsp_addr_d  = rsp_addr_q;
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    req_ready_o = 1'b0;
    pol_hit_o   = 1'b0;
    pol_miss_o  = 1'b0;
    pol_addr_o  = '0;
`ifdef SEQ_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // Pending hits drain before any miss is taken so recency stays exact.
        if (!fifo_empty) begin
          pol_hit_o  = 1'b1;
          pol_addr_o = fifo_mem[rd_ptr_q[BW_FIFO-1:0]];
          rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end else if (req_valid_i) begin
          req_ready_o = 1'b1;
          grp_d       = req_group_i;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        pol_miss_o = 1'b1;
        pol_addr_o = miss_addr;
        state_d    = ST_WAIT;
`ifdef SEQ_TIMEOUT_EN
        cnt_d      = '0;
`endif
      end
      ST_WAIT: begin
        pol_addr_o = miss_addr;
        if (pol_done_i) begin
          rsp_addr_d = {pol_addr_i[BW_CAP-1:BW_GRP], grp_q};
          state_d    = ST_RESP;
`ifdef SEQ_TIMEOUT_EN
          rsp_err_d  = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_addr_d = miss_addr;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      grp_q      <= '0;
      rsp_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef SEQ_TIMEOUT_EN
      cnt_q      <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      rsp_addr_q <= rsp_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef SEQ_TIMEOUT_EN
      cnt_q      <= cnt_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  // Storage needs no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clock_i) begin
    if (push) fifo_mem[wr_ptr_q[BW_FIFO-1:0]] <= hit_addr_i;
  end

endmodule

// File: tb/tb_set_cache_replacement_sequencer.sv
// Randomised + directed bench for set_cache_replacement_sequencer against a transaction-level model.
module tb_set_cache_replacement_sequencer;

  localparam int unsigned DEPTH = 4;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       hit_valid_i = 1'b0;
  logic [6:0] hit_addr_i = '0;
  logic       hit_ready_o;
  logic       req_valid_i = 1'b0;
  logic [4:0] req_group_i = '0;
  logic       req_ready_o;
  logic       rsp_valid_o;
  logic [6:0] rsp_addr_o;
  logic       rsp_err_o;
  logic       rsp_ready_i = 1'b0;
  logic       pol_hit_o;
  logic       pol_miss_o;
  logic [6:0] pol_addr_o;
  logic       pol_done_i = 1'b0;
  logic [6:0] pol_addr_i = '0;
  logic       busy_o;

  always #5 clock_i = ~clock_i;

  set_cache_replacement_sequencer #(
    .CACHE_BLOCK_CAPACITY(128),
    .CACHE_SET_SIZE      (4),
    .HIT_FIFO_DEPTH      (DEPTH),
    .TIMEOUT_CYCLES      (16)
  ) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .hit_valid_i(hit_valid_i),
    .hit_addr_i (hit_addr_i),
    .hit_ready_o(hit_ready_o),
    .req_valid_i(req_valid_i),
    .req_group_i(req_group_i),
    .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o),
    .rsp_addr_o (rsp_addr_o),
    .rsp_err_o  (rsp_err_o),
    .rsp_ready_i(rsp_ready_i),
    .pol_hit_o  (pol_hit_o),
    .pol_miss_o (pol_miss_o),
    .pol_addr_o (pol_addr_o),
    .pol_done_i (pol_done_i),
    .pol_addr_i (pol_addr_i),
    .busy_o     (busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: hit queue plus age of the outstanding miss (-1 = none).
  logic [6:0] hq[$];
  int         miss_t = -1;
  bit         have_rsp = 1'b0;
  logic [4:0] m_grp = '0;
  logic [6:0] m_rsp = '0;
  bit         m_err = 1'b0;
`ifdef SEQ_TIMEOUT_EN
  int         m_wait = 0;
`endif

  function automatic void model_clear();
    hq.delete();
    miss_t   = -1;
    have_rsp = 1'b0;
    m_err    = 1'b0;
  endfunction

  task automatic cycle(input bit hv, input logic [6:0] ha, input bit rv, input logic [4:0] rg,
                       input bit rr, input bit pd, input logic [6:0] pa);
    bit idle, exp_hit;
    int occ;
    @(negedge clock_i);
    hit_valid_i = hv; hit_addr_i = ha; req_valid_i = rv; req_group_i = rg;
    rsp_ready_i = rr; pol_done_i = pd; pol_addr_i = pa;
    #1;
    occ     = hq.size();
    idle    = (miss_t < 0);
    exp_hit = idle && (occ > 0);
    check_eq("hit_ready", 32'(hit_ready_o), 32'(occ < DEPTH));
    check_eq("busy", 32'(busy_o), 32'(!idle || occ > 0));
    check_eq("pol_hit", 32'(pol_hit_o), 32'(exp_hit));
    if (exp_hit) check_eq("pol_hit_addr", 32'(pol_addr_o), 32'(hq[0]));
    check_eq("pol_miss", 32'(pol_miss_o), 32'(miss_t == 0));
    if (miss_t >= 0 && !have_rsp) check_eq("pol_miss_addr", 32'(pol_addr_o), 32'({2'b00, m_grp}));
    check_eq("req_ready", 32'(req_ready_o), 32'(idle && occ == 0 && rv));
    check_eq("rsp_valid", 32'(rsp_valid_o), 32'(have_rsp));
    if (have_rsp) begin
      check_eq("rsp_addr", 32'(rsp_addr_o), 32'(m_rsp));
      check_eq("rsp_err", 32'(rsp_err_o), 32'(m_err));
    end
    if (exp_hit) void'(hq.pop_front());
    if (hv && occ < DEPTH) hq.push_back(ha);
    if (have_rsp) begin
      if (rr) begin have_rsp = 1'b0; miss_t = -1; end
    end else if (miss_t >= 1) begin
      miss_t++;
      if (pd) begin
        have_rsp = 1'b1; m_rsp = {pa[6:5], m_grp}; m_err = 1'b0;
      end
`ifdef SEQ_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == 16) begin have_rsp = 1'b1; m_rsp = {2'b00, m_grp}; m_err = 1'b1; end
      end
`endif
    end else if (miss_t == 0) begin
      miss_t = 1;
`ifdef SEQ_TIMEOUT_EN
      m_wait = 0;
`endif
    end else if (idle && occ == 0 && rv) begin
      miss_t = 0; m_grp = rg;
    end
  endtask

  task automatic do_reset();
    @(negedge clock_i);
    hit_valid_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0; pol_done_i = 1'b0;
    reset_i = 1'b1;
    #1;
    check_eq("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_eq("rst_rsp_addr", 32'(rsp_addr_o), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    check_eq("rst_pol_hit", 32'(pol_hit_o), 32'd0);
    check_eq("rst_pol_miss", 32'(pol_miss_o), 32'd0);
    check_eq("rst_pol_addr", 32'(pol_addr_o), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready_o), 32'd0);
    check_eq("rst_hit_ready", 32'(hit_ready_o), 32'd1);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    model_clear();
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset asserted mid-WAIT with hits buffered.
    cycle(0, 7'h00, 1, 5'h07, 0, 0, 7'h00);
    cycle(1, 7'h21, 0, 5'h00, 0, 0, 7'h00);
    cycle(1, 7'h22, 0, 5'h00, 0, 0, 7'h00);
    cycle(0, 7'h00, 0, 5'h00, 0, 0, 7'h00);
    check_eq("t1_busy_before", 32'(busy_o), 32'd1);
    do_reset();

    // Basic miss latency.
    cycle(0, 7'h00, 1, 5'h0B, 0, 1, 7'h4B);
    check_eq("t2_accept", 32'(req_ready_o), 32'd1);
    cycle(0, 7'h00, 0, 5'h00, 0, 1, 7'h4B);
    check_eq("t2_miss", 32'(pol_miss_o), 32'd1);
    check_eq("t2_miss_addr", 32'(pol_addr_o), 32'h0B);
    cycle(0, 7'h00, 0, 5'h00, 0, 1, 7'h4B);
    check_eq("t2_no_rsp_yet", 32'(rsp_valid_o), 32'd0);
    cycle(0, 7'h00, 0, 5'h00, 0, 0, 7'h00);
    check_eq("t2_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check_eq("t2_rsp_addr", 32'(rsp_addr_o), 32'h4B);

    // Fill the hit FIFO while the response is held.
    for (int i = 1; i <= 4; i++) cycle(1, 7'(i), 0, 5'h00, 0, 0, 7'h00);
    cycle(0, 7'h00, 1, 5'h13, 1, 0, 7'h00);
    check_eq("t3_full", 32'(hit_ready_o), 32'd0);
    check_eq("t3_rsp_held", 32'(rsp_addr_o), 32'h4B);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 7'h00, 1, 5'h13, 0, 0, 7'h00);
      check_eq("t3_drain_hit", 32'(pol_hit_o), 32'd1);
      check_eq("t3_drain_addr", 32'(pol_addr_o), 32'(i));
      check_eq("t4_req_blocked", 32'(req_ready_o), 32'd0);
    end
    cycle(0, 7'h00, 1, 5'h13, 0, 0, 7'h00);
    check_eq("t4_accept", 32'(req_ready_o), 32'd1);
    for (int i = 0; i < 9; i++) begin
      cycle(0, 7'h00, 0, 5'h00, 0, 0, 7'h00);
      check_eq("t4_pol_addr_static", 32'(pol_addr_o), 32'h13);
    end
    cycle(0, 7'h00, 0, 5'h00, 0, 1, 7'h60);
    cycle(0, 7'h00, 0, 5'h00, 1, 0, 7'h00);
    check_eq("t4_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check_eq("t4_rsp_addr", 32'(rsp_addr_o), 32'h73);

    // Push and pop in the same cycle with three entries queued.
    cycle(0, 7'h00, 1, 5'h02, 0, 1, 7'h20);
    cycle(0, 7'h00, 0, 5'h00, 0, 1, 7'h20);
    cycle(0, 7'h00, 0, 5'h00, 0, 1, 7'h20);
    for (int i = 0; i < 3; i++) cycle(1, 7'(8'h11 + i), 0, 5'h00, 0, 0, 7'h00);
    cycle(0, 7'h00, 0, 5'h00, 1, 0, 7'h00);
    cycle(1, 7'h14, 0, 5'h00, 0, 0, 7'h00);
    check_eq("t6_first_pop", 32'(pol_addr_o), 32'h11);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 7'h00, 0, 5'h00, 0, 0, 7'h00);
      if (i == 0) check_eq("t6_not_full", 32'(hit_ready_o), 32'd1);
      check_eq("t6_order", 32'(pol_addr_o), 32'(8'h12 + i));
    end
    cycle(0, 7'h00, 0, 5'h00, 0, 0, 7'h00);
    check_eq("t6_drained", 32'(busy_o), 32'd0);

`ifdef SEQ_TIMEOUT_EN
    // Policy never answers: fallback to way 0 with error flag.
    cycle(0, 7'h00, 1, 5'h13, 0, 0, 7'h00);
    for (int i = 0; i < 17; i++) cycle(0, 7'h00, 0, 5'h00, 0, 0, 7'h7F);
    cycle(0, 7'h00, 0, 5'h00, 1, 0, 7'h00);
    check_eq("t5_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check_eq("t5_rsp_addr", 32'(rsp_addr_o), 32'h13);
    check_eq("t5_rsp_err", 32'(rsp_err_o), 32'd1);
`endif

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle($urandom_range(0, 1) == 1, 7'($urandom), $urandom_range(0, 2) == 0,
                 5'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 7'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
